// File: rtl/el2_pkg.sv
// Shared types for the DCCM access arbiter: configuration record, arbiter
// state encoding and the requester id carried on read responses.
package el2_pkg;

    typedef struct packed {
        int unsigned DCCM_BITS;
        int unsigned DCCM_FDATA_WIDTH;
        int unsigned DCCM_BYTE_WIDTH;
    } el2_param_t;

    // 64 KiB DCCM, 32-bit data plus 7 ECC bits, 4-byte words.
    localparam el2_param_t EL2_PARAM_DEFAULT = '{
        DCCM_BITS:        16,
        DCCM_FDATA_WIDTH: 39,
        DCCM_BYTE_WIDTH:  4
    };

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } el2_dccm_arb_state_t;

    typedef enum logic {
        LSU = 1'b0,
        DMA = 1'b1
    } el2_dccm_req_id_e;

endpackage

// File: rtl/el2_dccm_init_seq.sv
// Post-reset zero-fill sequencer: walks a word counter across the whole
// DCCM while the arbiter is in INIT and flags the final word.
module el2_dccm_init_seq #(
    parameter int CNT_W = 14
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             active,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    logic [CNT_W-1:0] count_q;

    // One word is written per active cycle; an async reset restarts at word 0.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            count_q <= '0;
        end else if (active) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;
    // Asserted during the write of the last word (counter all ones).
    assign done  = active && (&count_q);

endmodule

// File: rtl/el2_lsu_dccm_arb.sv
// Single-port DCCM access controller. Arbitrates LSU, DMA and the post-reset
// zero-fill sequencer onto one memory port, tags read data with its owner one
// cycle after the read, and promotes DMA over LSU after a bounded wait.
//
// Handshake: a requester raises *_req_valid with a stable payload and holds
// both until it sees *_req_ready high in the same cycle; that cycle is the
// transfer. Ready is combinational from valid and state, and a raised valid
// is never withdrawn before its transfer.
module el2_lsu_dccm_arb
    import el2_pkg::*;
#(
    parameter el2_param_t pt           = EL2_PARAM_DEFAULT,
    parameter int         DMA_MAX_WAIT = 4,
    parameter int         INIT_EN      = 1
) (
    input  logic                             clk,
    input  logic                             rst_l,

    input  logic                             lsu_req_valid,
    output logic                             lsu_req_ready,
    input  logic                             lsu_req_write,
    input  logic [pt.DCCM_BITS-1:0]          lsu_req_addr_lo,
    input  logic [pt.DCCM_BITS-1:0]          lsu_req_addr_hi,
    input  logic [pt.DCCM_FDATA_WIDTH-1:0]   lsu_req_wdata_lo,
    input  logic [pt.DCCM_FDATA_WIDTH-1:0]   lsu_req_wdata_hi,

    input  logic                             dma_req_valid,
    output logic                             dma_req_ready,
    input  logic                             dma_req_write,
    input  logic [pt.DCCM_BITS-1:0]          dma_req_addr_lo,
    input  logic [pt.DCCM_BITS-1:0]          dma_req_addr_hi,
    input  logic [pt.DCCM_FDATA_WIDTH-1:0]   dma_req_wdata_lo,
    input  logic [pt.DCCM_FDATA_WIDTH-1:0]   dma_req_wdata_hi,

    output logic                             dccm_wren,
    output logic                             dccm_rden,
    output logic [pt.DCCM_BITS-1:0]          dccm_wr_addr_lo,
    output logic [pt.DCCM_BITS-1:0]          dccm_wr_addr_hi,
    output logic [pt.DCCM_BITS-1:0]          dccm_rd_addr_lo,
    output logic [pt.DCCM_BITS-1:0]          dccm_rd_addr_hi,
    output logic [pt.DCCM_FDATA_WIDTH-1:0]   dccm_wr_data_lo,
    output logic [pt.DCCM_FDATA_WIDTH-1:0]   dccm_wr_data_hi,
    input  logic [pt.DCCM_FDATA_WIDTH-1:0]   dccm_rd_data_lo,
    input  logic [pt.DCCM_FDATA_WIDTH-1:0]   dccm_rd_data_hi,

    output logic                             rsp_valid,
    output logic                             rsp_id,
    output logic [pt.DCCM_FDATA_WIDTH-1:0]   rsp_data_lo,
    output logic [pt.DCCM_FDATA_WIDTH-1:0]   rsp_data_hi,

    output logic                             init_done,
    output el2_dccm_arb_state_t              dbg_state
);

    localparam int unsigned AW = pt.DCCM_BITS;
    localparam int unsigned FW = pt.DCCM_FDATA_WIDTH;
    localparam int unsigned CW = pt.DCCM_BITS - 2;
    localparam int unsigned WW = (DMA_MAX_WAIT < 1) ? 1 : $clog2(DMA_MAX_WAIT + 1);

    el2_dccm_arb_state_t state_q, state_d;
    el2_dccm_req_id_e    grant_id;
    el2_dccm_req_id_e    rsp_id_q;

    logic [WW-1:0] dma_wait_q, dma_wait_d;
    logic          dma_pri;
    logic          grant_lsu, grant_dma, grant;
    logic          init_active, init_last;
    logic [CW-1:0] init_count;
    logic [AW-1:0] init_addr;
    logic          rsp_pend_q;
    logic          init_done_q;

    logic          win_write;
    logic [AW-1:0] win_addr_lo, win_addr_hi;
    logic [FW-1:0] win_wdata_lo, win_wdata_hi;

    el2_dccm_init_seq #(
        .CNT_W (CW)
    ) u_init_seq (
        .clk    (clk),
        .rst_l  (rst_l),
        .active (init_active),
        .count  (init_count),
        .done   (init_last)
    );

    // Word counter scaled to a byte address; lo and hi banks get the same word.
    assign init_addr = AW'(init_count * pt.DCCM_BYTE_WIDTH);

    // DMA has been blocked long enough to outrank the LSU this cycle.
    assign dma_pri = (dma_wait_q == WW'(DMA_MAX_WAIT));

    // Next-state and grant selection; nothing is granted outside RUN.
    always_comb begin
        state_d     = state_q;
        init_active = 1'b0;
        grant_lsu   = 1'b0;
        grant_dma   = 1'b0;
        case (state_q)
            WAIT: begin
                if (INIT_EN != 0) state_d = INIT;
                else              state_d = RUN;
            end
            INIT: begin
                init_active = 1'b1;
                if (init_last) state_d = RUN;
            end
            RUN: begin
                if (dma_req_valid && (dma_pri || !lsu_req_valid)) grant_dma = 1'b1;
                else if (lsu_req_valid)                           grant_lsu = 1'b1;
            end
            default: state_d = WAIT;
        endcase
    end

    assign grant         = grant_lsu | grant_dma;
    assign lsu_req_ready = grant_lsu;
    assign dma_req_ready = grant_dma;

    // Winner id and payload mux.
    always_comb begin
        grant_id     = LSU;
        win_write    = lsu_req_write;
        win_addr_lo  = lsu_req_addr_lo;
        win_addr_hi  = lsu_req_addr_hi;
        win_wdata_lo = lsu_req_wdata_lo;
        win_wdata_hi = lsu_req_wdata_hi;
        if (grant_dma) begin
            grant_id     = DMA;
            win_write    = dma_req_write;
            win_addr_lo  = dma_req_addr_lo;
            win_addr_hi  = dma_req_addr_hi;
            win_wdata_lo = dma_req_wdata_lo;
            win_wdata_hi = dma_req_wdata_hi;
        end
    end

    // Memory strobes and buses; whatever is not in use this cycle is driven 0.
    always_comb begin
        dccm_wren       = 1'b0;
        dccm_rden       = 1'b0;
        dccm_wr_addr_lo = '0;
        dccm_wr_addr_hi = '0;
        dccm_rd_addr_lo = '0;
        dccm_rd_addr_hi = '0;
        dccm_wr_data_lo = '0;
        dccm_wr_data_hi = '0;
        if (init_active) begin
            // All-zero data is a valid ECC codeword, so zero-fill needs no encoder.
            dccm_wren       = 1'b1;
            dccm_wr_addr_lo = init_addr;
            dccm_wr_addr_hi = init_addr;
        end else if (grant && win_write) begin
            dccm_wren       = 1'b1;
            dccm_wr_addr_lo = win_addr_lo;
            dccm_wr_addr_hi = win_addr_hi;
            dccm_wr_data_lo = win_wdata_lo;
            dccm_wr_data_hi = win_wdata_hi;
        end else if (grant) begin
            dccm_rden       = 1'b1;
            dccm_rd_addr_lo = win_addr_lo;
            dccm_rd_addr_hi = win_addr_hi;
        end
    end

    // Starvation counter: counts blocked DMA cycles in RUN, saturates, clears on grant.
    always_comb begin
        dma_wait_d = dma_wait_q;
        if (grant_dma) begin
            dma_wait_d = '0;
        end else if ((state_q == RUN) && dma_req_valid && !dma_pri) begin
            dma_wait_d = dma_wait_q + 1'b1;
        end
    end

    // State, starvation counter, pending read tag and the usable flag.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= WAIT;
            dma_wait_q  <= '0;
            rsp_pend_q  <= 1'b0;
            rsp_id_q    <= LSU;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dma_wait_q  <= dma_wait_d;
            rsp_pend_q  <= dccm_rden;
            if (dccm_rden) rsp_id_q <= grant_id;
            // Looks at the next state so the flag rises right after the last init write.
            init_done_q <= (state_d == RUN);
        end
    end

    assign rsp_valid   = rsp_pend_q;
    assign rsp_id      = rsp_id_q;
    // Memory returns data one cycle after rden; forward it only when a read is pending.
    assign rsp_data_lo = rsp_pend_q ? dccm_rd_data_lo : '0;
    assign rsp_data_hi = rsp_pend_q ? dccm_rd_data_hi : '0;
    assign init_done   = init_done_q;
    assign dbg_state   = state_q;

endmodule
